vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_machine_param.sv | 161 ++++++++++++++++
 tb/tb_vending_machine_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Card-operated vending controller with a parameterised slot count and per-slot stock counters.
// Selection is two decimal digits; each price covers a group of consecutive slots.
module vending_machine_param #(
  parameter int NUM_SLOTS  = 20,
  parameter int STOCK_W    = 4,
  parameter int RELOAD_QTY = 10,
  parameter int TIMEOUT    = 5,
  parameter int COST_GROUP = 4,
  parameter int COST_W     = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CARD_IN,
  input  logic              KEY_PRESS,
  input  logic [3:0]        ITEM_CODE,
  input  logic              CANCEL,
  input  logic              VALID_TRAN,
  input  logic              DOOR_OPEN,
  input  logic              RELOAD,
  output logic              VEND,
  output logic              INVALID_SEL,
  output logic              FAILED_TRAN,
  output logic [COST_W-1:0] COST
);

  localparam int         SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam int         COST_MAX = (1 << COST_W) - 1;

  typedef enum logic [3:0] {
    IDLE, RELOAD_ST, DIGIT1, DIGIT2, CHECK, INVALID, PAY, FAILED, VEND_WAIT, DOOR
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          digit1_q, digit1_d;
  logic [3:0]          digit2_q, digit2_d;
  logic [7:0]          waitCnt_q, waitCnt_d;
  logic [STOCK_W-1:0]  stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0]  stock_d [NUM_SLOTS];
  logic                vend_q, invSel_q, failed_q;
  logic [COST_W-1:0]   cost_q, cost_d;

  logic [7:0]          slotIdx;
  logic [SLOT_W-1:0]   slotSel;
  logic                slotInRange;
  logic [STOCK_W-1:0]  selStock;
  logic [7:0]          costRaw;
  logic [COST_W-1:0]   costSat;
  logic                timeout;
  logic                isWaitState;
  logic                vendGo;

  // Slot decode from the captured digits; out-of-range selections never touch the stock array.
  always_comb begin
    slotIdx     = {4'd0, digit1_q} * 8'd10 + {4'd0, digit2_q};
    slotSel     = slotIdx[SLOT_W-1:0];
    slotInRange = (digit1_q <= 4'd9) && (digit2_q <= 4'd9) && (slotIdx < 8'(NUM_SLOTS));
    selStock    = slotInRange ? stock_q[slotSel] : '0;
    costRaw     = slotIdx / 8'(COST_GROUP) + 8'd1;
    costSat     = (costRaw > 8'(COST_MAX)) ? COST_W'(COST_MAX) : costRaw[COST_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    digit1_d    = digit1_q;
    digit2_d    = digit2_q;
    vendGo      = 1'b0;
    timeout     = (waitCnt_q == TMO_LAST);
    isWaitState = (state_q == DIGIT1) || (state_q == DIGIT2) ||
                  (state_q == PAY)    || (state_q == VEND_WAIT);
    case (state_q)
      IDLE: begin
        if (RELOAD)       state_d = RELOAD_ST;
        else if (CARD_IN) state_d = DIGIT1;
      end
      RELOAD_ST: state_d = IDLE;
      DIGIT1: begin
        if (CANCEL) state_d = IDLE;
        else if (KEY_PRESS) begin
          digit1_d = ITEM_CODE;
          state_d  = DIGIT2;
        end else if (timeout) state_d = INVALID;
      end
      DIGIT2: begin
        if (CANCEL) state_d = IDLE;
        else if (KEY_PRESS) begin
          digit2_d = ITEM_CODE;
          state_d  = CHECK;
        end else if (timeout) state_d = INVALID;
      end
      CHECK: begin
        if (!slotInRange || (selStock == '0)) state_d = INVALID;
        else                                  state_d = PAY;
      end
      INVALID: state_d = IDLE;
      PAY: begin
        if (CANCEL) state_d = IDLE;
        else if (VALID_TRAN) begin
          state_d = VEND_WAIT;
          vendGo  = 1'b1;
        end else if (timeout) state_d = FAILED;
      end
      FAILED: state_d = IDLE;
      VEND_WAIT: begin
        if (DOOR_OPEN)    state_d = DOOR;
        else if (timeout) state_d = IDLE;
      end
      DOOR: begin
        if (!DOOR_OPEN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state change, so entry into any waiting state begins at zero.
    if (state_d != state_q) waitCnt_d = '0;
    else if (isWaitState)   waitCnt_d = waitCnt_q + 8'd1;
    else                    waitCnt_d = '0;

    cost_d = (state_d == PAY) ? costSat : '0;
  end

  always_comb begin
    stock_d = stock_q;
    if (state_q == RELOAD_ST) begin
      for (int i = 0; i < NUM_SLOTS; i++) stock_d[i] = STOCK_W'(RELOAD_QTY);
    end else if (vendGo && (selStock != '0)) begin
      stock_d[slotSel] = selStock - STOCK_W'(1);
    end
  end

  // Outputs are registered from the next state so they stay Moore-decoded yet glitch-free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      digit1_q  <= '0;
      digit2_q  <= '0;
      waitCnt_q <= '0;
      stock_q   <= '{default: '0};
      vend_q    <= 1'b0;
      invSel_q  <= 1'b0;
      failed_q  <= 1'b0;
      cost_q    <= '0;
    end else begin
      state_q   <= state_d;
      digit1_q  <= digit1_d;
      digit2_q  <= digit2_d;
      waitCnt_q <= waitCnt_d;
      stock_q   <= stock_d;
      vend_q    <= (state_d == VEND_WAIT);
      invSel_q  <= (state_d == INVALID);
      failed_q  <= (state_d == FAILED);
      cost_q    <= cost_d;
    end
  end

  assign VEND        = vend_q;
  assign INVALID_SEL = invSel_q;
  assign FAILED_TRAN = failed_q;
  assign COST        = cost_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: stimulus queues expected output events,
// a negedge monitor pops and compares them as the DUT produces outputs.
module tb_vending_machine_param;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CARD_IN, KEY_PRESS, CANCEL, VALID_TRAN, DOOR_OPEN, RELOAD;
  logic [3:0] ITEM_CODE;
  logic       VEND, INVALID_SEL, FAILED_TRAN;
  logic [2:0] COST;

  localparam int EV_INV   = 1;
  localparam int EV_FAILT = 2;
  localparam int EV_VEND  = 3;
  localparam int EV_COST  = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t expQ[$];
  int  checksTotal  = 0;
  int  checksPassed = 0;
  logic       prevVend = 1'b0;
  logic [2:0] prevCost = 3'd0;

  vending_machine_param dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CARD_IN    (CARD_IN),
    .KEY_PRESS  (KEY_PRESS),
    .ITEM_CODE  (ITEM_CODE),
    .CANCEL     (CANCEL),
    .VALID_TRAN (VALID_TRAN),
    .DOOR_OPEN  (DOOR_OPEN),
    .RELOAD     (RELOAD),
    .VEND       (VEND),
    .INVALID_SEL(INVALID_SEL),
    .FAILED_TRAN(FAILED_TRAN),
    .COST       (COST)
  );

  always #5 CLK = ~CLK;

  function automatic string evName(input int k);
    case (k)
      EV_INV:   return "invalid_sel";
      EV_FAILT: return "failed_tran";
      EV_VEND:  return "vend";
      EV_COST:  return "cost";
      default:  return "none";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic expectEvent(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    expQ.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    checksTotal++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL unexpected_event: got %s=%0d, expected no output", evName(k), v);
    end else begin
      e = expQ.pop_front();
      if (e.kind == k && e.val == v) checksPassed++;
      else $display("[TB] FAIL event_order: got %s=%0d, expected %s=%0d",
                    evName(k), v, evName(e.kind), e.val);
    end
  endtask

  // Each cycle INVALID_SEL/FAILED_TRAN are high counts as an event, so over-long pulses surface.
  always @(negedge CLK) begin
    if (INVALID_SEL) observe(EV_INV, 0);
    if (FAILED_TRAN) observe(EV_FAILT, 0);
    if (VEND && !prevVend) observe(EV_VEND, 0);
    if (COST != 3'd0 && COST != prevCost) observe(EV_COST, int'(COST));
    prevVend = VEND;
    prevCost = COST;
  end

  // One cycle of inputs: drive at a negedge, return at the next negedge.
  task automatic applyStimulus(input logic card, input logic key, input logic [3:0] code,
                               input logic cancel, input logic valid, input logic door,
                               input logic reload);
    CARD_IN    = card;
    KEY_PRESS  = key;
    ITEM_CODE  = code;
    CANCEL     = cancel;
    VALID_TRAN = valid;
    DOOR_OPEN  = door;
    RELOAD     = reload;
    @(negedge CLK);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(0, 0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic selectSlot(input logic [3:0] d1, input logic [3:0] d2);
    applyStimulus(1, 0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 1, d1, 0, 0, 0, 0);
    applyStimulus(0, 1, d2, 0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1'b1;
    CARD_IN = 0; KEY_PRESS = 0; ITEM_CODE = 4'd0; CANCEL = 0;
    VALID_TRAN = 0; DOOR_OPEN = 0; RELOAD = 0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_vend", int'(VEND), 0);
    checkOutput("reset_invalid", int'(INVALID_SEL), 0);
    checkOutput("reset_failed", int'(FAILED_TRAN), 0);
    checkOutput("reset_cost", int'(COST), 0);
    RESET = 1'b0;
    idleCycles(2);

    // Empty machine: slot 5 has no stock
    expectEvent(EV_INV, 0);
    selectSlot(4'd0, 4'd5);
    idleCycles(1);
    checkOutput("empty_invalid", int'(INVALID_SEL), 1);
    idleCycles(1);
    checkOutput("invalid_one_cycle", int'(INVALID_SEL), 0);

    // Reload, buy slot 13 paying on the second PAY cycle
    applyStimulus(0, 0, 4'd0, 0, 0, 0, 1);
    idleCycles(1);
    expectEvent(EV_COST, 4);
    expectEvent(EV_VEND, 0);
    selectSlot(4'd1, 4'd3);
    idleCycles(1);
    checkOutput("cost_slot13", int'(COST), 4);
    idleCycles(1);
    checkOutput("cost_slot13_c2", int'(COST), 4);
    applyStimulus(0, 0, 4'd0, 0, 1, 0, 0);
    checkOutput("vend_wait_vend", int'(VEND), 1);
    checkOutput("vend_wait_cost", int'(COST), 0);
    applyStimulus(0, 0, 4'd0, 0, 0, 1, 0);
    checkOutput("door_vend_low", int'(VEND), 0);
    applyStimulus(0, 0, 4'd0, 0, 0, 1, 0);
    applyStimulus(0, 0, 4'd0, 0, 0, 1, 0);
    idleCycles(1);

    // Index 20 is past the last slot; digit 12 is illegal
    expectEvent(EV_INV, 0);
    selectSlot(4'd2, 4'd0);
    idleCycles(1);
    checkOutput("index20_invalid", int'(INVALID_SEL), 1);
    idleCycles(1);
    expectEvent(EV_INV, 0);
    selectSlot(4'd0, 4'd12);
    idleCycles(1);
    checkOutput("digit12_invalid", int'(INVALID_SEL), 1);
    idleCycles(1);

    // DIGIT1 times out after exactly TIMEOUT cycles
    expectEvent(EV_INV, 0);
    applyStimulus(1, 0, 4'd0, 0, 0, 0, 0);
    idleCycles(4);
    checkOutput("digit1_before_timeout", int'(INVALID_SEL), 0);
    idleCycles(1);
    checkOutput("digit1_timeout", int'(INVALID_SEL), 1);
    idleCycles(1);

    // Key on the DIGIT2 timeout cycle is still accepted; then cancel in PAY
    expectEvent(EV_COST, 1);
    applyStimulus(1, 0, 4'd0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4'd0, 0, 0, 0, 0);
    idleCycles(4);
    applyStimulus(0, 1, 4'd1, 0, 0, 0, 0);
    idleCycles(1);
    checkOutput("late_key_cost", int'(COST), 1);
    applyStimulus(0, 0, 4'd0, 1, 0, 0, 0);
    checkOutput("cancel_cost", int'(COST), 0);
    checkOutput("cancel_vend", int'(VEND), 0);
    idleCycles(2);

    // Payment never approved
    expectEvent(EV_COST, 2);
    expectEvent(EV_FAILT, 0);
    selectSlot(4'd0, 4'd5);
    idleCycles(1);
    idleCycles(4);
    checkOutput("pay_before_timeout", int'(FAILED_TRAN), 0);
    checkOutput("pay_cost_slot5", int'(COST), 2);
    idleCycles(1);
    checkOutput("pay_timeout_failed", int'(FAILED_TRAN), 1);
    checkOutput("failed_cost", int'(COST), 0);
    idleCycles(1);
    checkOutput("failed_one_cycle", int'(FAILED_TRAN), 0);

    // RELOAD beats CARD_IN; no DIGIT1 timeout must follow
    applyStimulus(1, 0, 4'd0, 0, 0, 0, 1);
    idleCycles(8);

    // Drain slot 0: ten vends, the eleventh is rejected
    for (int n = 0; n < 11; n++) begin
      if (n < 10) begin
        expectEvent(EV_COST, 1);
        expectEvent(EV_VEND, 0);
        selectSlot(4'd0, 4'd0);
        idleCycles(1);
        applyStimulus(0, 0, 4'd0, 0, 1, 0, 0);
        applyStimulus(0, 0, 4'd0, 0, 0, 1, 0);
        idleCycles(1);
      end else begin
        expectEvent(EV_INV, 0);
        selectSlot(4'd0, 4'd0);
        idleCycles(1);
        checkOutput("slot0_sold_out", int'(INVALID_SEL), 1);
        idleCycles(1);
      end
    end

    // Asynchronous reset while vending clears outputs and stock
    expectEvent(EV_COST, 4);
    expectEvent(EV_VEND, 0);
    selectSlot(4'd1, 4'd3);
    idleCycles(1);
    applyStimulus(0, 0, 4'd0, 0, 1, 0, 0);
    checkOutput("pre_reset_vend", int'(VEND), 1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("async_reset_vend", int'(VEND), 0);
    checkOutput("async_reset_cost", int'(COST), 0);
    @(negedge CLK);
    RESET = 1'b0;
    idleCycles(1);
    expectEvent(EV_INV, 0);
    selectSlot(4'd1, 4'd3);
    idleCycles(1);
    checkOutput("stock_cleared_invalid", int'(INVALID_SEL), 1);
    idleCycles(5);

    checkOutput("events_outstanding", expQ.size(), 0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
